// File: rtl/reg_16_pkg.sv
// Shared constants and types for the reg_16 storage register.
// Build option: define REG_16_TRISTATE_EN for Z-driving read ports.
package reg_16_pkg;

    localparam int REG_WIDTH = 16;
    localparam logic [REG_WIDTH-1:0] REG_RESET_VALUE = 16'h0000;

    typedef logic [REG_WIDTH-1:0] reg_word_t;

endpackage

// File: rtl/reg_16_bit.sv
// One storage bit: async active-low reset flop with load enable and two gated reads.
// REG_16_TRISTATE_EN selects Z (defined) or 0 (undefined) on a disabled read.
module reg_16_bit #(
    parameter logic RESET_BIT = 1'b0
) (
    output logic out_a,
    output logic out_b,
    input  logic d,
    input  logic load,
    input  logic ra,
    input  logic rb,
    input  logic clk,
    input  logic rst_n
);

    logic q;

    // Hold when load is low so an undriven/X write bus cannot disturb q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= RESET_BIT;
        else if (load)
            q <= d;
    end

`ifdef REG_16_TRISTATE_EN
    assign out_a = ra ? q : 1'bz;
    assign out_b = rb ? q : 1'bz;
`else
    assign out_a = ra & q;
    assign out_b = rb & q;
`endif

endmodule

// File: rtl/reg_16.sv
// reg_16: WIDTH-bit register, one write port, two independently enabled read ports.
// Build option: REG_16_TRISTATE_EN makes disabled read ports float for shared buses.
module reg_16
    import reg_16_pkg::*;
#(
    parameter int               WIDTH       = REG_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(REG_RESET_VALUE)
) (
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB,
    input  logic [WIDTH-1:0] I,
    input  logic             W,
    input  logic             RA,
    input  logic             RB,
    input  logic             clk,
    input  logic             rst_n
);

    // Controls fan out unchanged; each bit slice carries its own reset value.
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        reg_16_bit #(
            .RESET_BIT (RESET_VALUE[b])
        ) u_bit (
            .out_a (OutA[b]),
            .out_b (OutB[b]),
            .d     (I[b]),
            .load  (W),
            .ra    (RA),
            .rb    (RB),
            .clk   (clk),
            .rst_n (rst_n)
        );
    end

endmodule

// File: tb/tb_reg_16.sv
// Scoreboard bench for reg_16: driver pushes expected port values, monitor pops at negedge.
module tb_reg_16;
    import reg_16_pkg::*;

`ifdef REG_16_TRISTATE_EN
    localparam reg_word_t DIS = 16'hzzzz;
`else
    localparam reg_word_t DIS = 16'h0000;
`endif

    logic      clk, rst_n, W, RA, RB;
    reg_word_t I, OutA, OutB;

    reg_16 dut (
        .OutA  (OutA),
        .OutB  (OutB),
        .I     (I),
        .W     (W),
        .RA    (RA),
        .RB    (RB),
        .clk   (clk),
        .rst_n (rst_n)
    );

    typedef struct {
        reg_word_t a;
        reg_word_t b;
        string     nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the word the register should hold, plus what was driven last.
    reg_word_t mq;
    logic      cur_w, cur_rst;
    reg_word_t cur_i;

    initial begin
        clk = 1'b0;
        #40;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks += 2;
            if (OutA !== e.a) begin
                errors++;
                $display("FAIL %s OutA got %h want %h", e.nm, OutA, e.a);
            end
            if (OutB !== e.b) begin
                errors++;
                $display("FAIL %s OutB got %h want %h", e.nm, OutB, e.b);
            end
        end
    end

    // Applies new inputs just after a rising edge; the model first commits that edge's write.
    task automatic step(input logic w, input reg_word_t i, input logic ra, input logic rb,
                        input logic rst, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        if (cur_rst && cur_w) mq = cur_i;
        W = w; I = i; RA = ra; RB = rb; rst_n = rst;
        cur_w = w; cur_i = i; cur_rst = rst;
        if (!rst) mq = REG_RESET_VALUE;
        e.a  = ra ? mq : DIS;
        e.b  = rb ? mq : DIS;
        e.nm = nm;
        sb.push_back(e);
    endtask

    initial begin
        logic w, ra, rb, rst;
        reg_word_t i;
        rst_n = 1'b1; W = 1'b0; I = '0; RA = 1'b1; RB = 1'b1;
        cur_w = 1'b0; cur_rst = 1'b0; cur_i = '0; mq = REG_RESET_VALUE;
        #2 rst_n = 1'b0;
        #3;
        checks++;
        if (OutA !== 16'h0000 || OutB !== 16'h0000) begin
            errors++;
            $display("FAIL reset_noclk_en got %h/%h want 0000/0000", OutA, OutB);
        end
        RA = 1'b0; RB = 1'b0;
        #3;
        checks++;
        if (OutA !== DIS || OutB !== DIS) begin
            errors++;
            $display("FAIL reset_noclk_dis got %h/%h want %h/%h", OutA, OutB, DIS, DIS);
        end

        step(0, 16'h0000, 1, 1, 0, "reset_clk");
        step(0, 16'h0000, 0, 0, 1, "release");
        step(1, 16'h0099, 0, 0, 1, "wr_0099");
        step(0, 16'hxxxx, 1, 0, 1, "rd_a_0099");
        step(1, 16'h0555, 1, 0, 1, "ow_pre_edge");
        step(0, 16'h0555, 1, 0, 1, "ow_post_edge");
        step(0, 16'h0555, 1, 1, 1, "rd_b_0555");
        for (int k = 0; k < 5; k++)
            step(0, (k % 2) ? 16'h1234 : 16'hFFFF, 1, 0, 1, "hold");
        step(0, 16'hFFFF, 1, 1, 0, "async_rst");
        step(1, 16'hBEEF, 1, 1, 0, "wr_in_rst");
        step(1, 16'hA5A5, 1, 1, 1, "rst_release_w");
        step(1, 16'hA5A5, 1, 1, 1, "wr_a5a5");
        step(0, 16'h0000, 0, 0, 1, "en_00");
        step(0, 16'h0000, 1, 0, 1, "en_10");
        step(0, 16'h0000, 0, 1, 1, "en_01");
        step(0, 16'h0000, 1, 1, 1, "en_11");

        for (int k = 0; k < 300; k++) begin
            w   = ($urandom_range(0, 2) == 0);
            ra  = $urandom_range(0, 1);
            rb  = $urandom_range(0, 1);
            rst = ($urandom_range(0, 19) != 0);
            i   = reg_word_t'($urandom);
            if (!w && $urandom_range(0, 3) == 0) i = 16'hxxxx;
            step(w, i, ra, rb, rst, "rand");
        end

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_16.md
# reg_16

A 16-bit general-purpose storage register with one write port and two independently enabled read ports, A and B. It sits as one entry of a register-file-style datapath. Data on `I` is captured on a rising clock edge when `W` is asserted. The stored word is driven onto `OutA` and/or `OutB` whenever the matching read enable is high. Read ports are combinational from the stored word, so several registers can share bus A and bus B.

## Interface
- `WIDTH`, default 16: data width of `I`, `OutA`, `OutB` and the stored word.
- `RESET_VALUE`, default 16'h0000: value loaded into the stored word by reset.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `I`  input  WIDTH  write data.
- `W`  input  1  write enable, sampled on rising `clk`.
- `RA`  input  1  read enable for port A.
- `RB`  input  1  read enable for port B.
- `OutA`  output  WIDTH  read port A.
- `OutB`  output  WIDTH  read port B.
- Positional port order: `OutA`, `OutB`, `I`, `W`, `RA`, `RB`, `clk`, `rst_n`.

## Operation
- Stored word `Q` is WIDTH flops.
- Rising `clk` with `W`=1 and `rst_n`=1: `Q` <= `I`.
- Rising `clk` with `W`=0: `Q` holds.
- `rst_n`=0: `Q` = `RESET_VALUE` immediately, independent of `clk`. While reset is held, writes are ignored.
- Read ports:
  - `OutA` = `Q` when `RA`=1, otherwise the disabled value (see Configuration).
  - `OutB` behaves the same with `RB`.
- `RA` and `RB` are fully independent. Both may be high at once, and both ports then show `Q`.
- Reads show the pre-edge `Q` until the write edge, then the new `Q`. There is no write-through of `I`.
- X/Z on `I` while `W`=0 must not disturb `Q`.

## Timing
- Write latency: 1 edge. `Q` updates at the rising edge where `W`=1.
- Read latency: combinational from `RA`/`RB`/`Q`; no clock cycle.
- Reset assertion is asynchronous. Reset deassertion takes effect for the next rising edge.
- Reset state:
  - `Q` = `RESET_VALUE`.
  - `OutA`/`OutB` show `RESET_VALUE` if enabled, otherwise the disabled value.
- `W`=1 while `rst_n` deasserts at the same edge: no write occurs on that edge.

## Configuration
- `REG_16_TRISTATE_EN`:
  - Defined: a disabled read port drives all-Z, for shared-bus use.
  - Not defined: a disabled read port drives all-zero, for mux/OR-bus use.
- Enabled behaviour is identical in both builds.

## Structure
- Shared package `reg_16_pkg` holds:
  - `REG_WIDTH` = 16.
  - `REG_RESET_VALUE` = 16'h0000.
  - Typedef `reg_word_t` (logic [REG_WIDTH-1:0]).
- Sub-module `reg_16_bit`: one flop with async active-low reset, load enable and two gated read outputs. It is instantiated WIDTH times by a generate loop. The top level only distributes the controls.

## Test plan
- Reset: `rst_n`=0 with `RA`=`RB`=1 -> `OutA`=`OutB`=16'h0000 immediately and with no clock; with `RA`=`RB`=0, both outputs show Z (TRISTATE build) or 0.
- Write then read A: `I`=16'h0099, `W` pulsed across one rising edge, then `I`=X and `RA`=1 -> `OutA`=16'h0099; `OutB` disabled value.
- Overwrite with A enabled: `I`=16'h0555, `W`=1 across the next edge -> `OutA` changes from 16'h0099 to 16'h0555 at that edge; then `RB`=1 -> `OutB`=16'h0555.
- Hold: `W`=0 for 5 edges with `I` toggling 16'hFFFF/16'h1234 -> `OutA` stays 16'h0555.
- Async reset mid-operation: `Q`=16'h0555, drop `rst_n` between edges -> outputs go to 16'h0000 before the next edge; a `W`=1 edge while reset is held leaves 16'h0000.
- Read-enable independence: toggle `RA` and `RB` in all four combinations with `Q`=16'hA5A5 -> each port shows 16'hA5A5 only when its own enable is 1.
